// File: rtl/cdc_fifo_gray_fill.sv
// Dual-clock FIFO. Binary pointers cross domains as registered Gray codes.
// Each side reports a conservative fill level; the source side also reports almost-full.
module cdc_fifo_gray_fill #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LOG_DEPTH   = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = 2**LOG_DEPTH - 1
) (
    input  logic                  src_clk_i,
    input  logic                  src_rst_ni,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    output logic [LOG_DEPTH:0]    src_fill_o,
    output logic                  src_almost_full_o,

    input  logic                  dst_clk_i,
    input  logic                  dst_rst_ni,
    output logic [DATA_WIDTH-1:0] dst_data_o,
    output logic                  dst_valid_o,
    input  logic                  dst_ready_i,
    output logic [LOG_DEPTH:0]    dst_fill_o
);

    localparam int unsigned DEPTH = 2**LOG_DEPTH;
    localparam int unsigned PW    = LOG_DEPTH + 1;

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t FULL_LEVEL = PW'(DEPTH);
    localparam ptr_t AF_LEVEL   = PW'(AF_THRESH);

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // ---------------- source domain ----------------
    ptr_t                   wbin_q, wbin_d, wgray_q;
    ptr_t                   rbin_s;
    ptr_t [SYNC_STAGES-1:0] rgray_sync_q;
    ptr_t                   rgray_q;
    logic                   push;

    assign rbin_s            = gray2bin(rgray_sync_q[SYNC_STAGES-1]);
    assign src_fill_o        = wbin_q - rbin_s;
    assign src_ready_o       = (src_fill_o != FULL_LEVEL);
    assign src_almost_full_o = (src_fill_o >= AF_LEVEL);
    assign push              = src_valid_i && src_ready_o;
    assign wbin_d            = push ? wbin_q + ptr_t'(1) : wbin_q;

    // NOTE: the Gray copy is computed from the next binary value so that both
    // registers move on the same edge and the crossing bus is glitch-free.
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            wbin_q       <= '0;
            wgray_q      <= '0;
            rgray_sync_q <= '0;
        end else begin
            wbin_q       <= wbin_d;
            wgray_q      <= bin2gray(wbin_d);
            rgray_sync_q <= {rgray_sync_q[SYNC_STAGES-2:0], rgray_q};
        end
    end

    // NOTE: storage is deliberately not reset; slots are only read once the
    // pointers say they hold data, and dropping reset keeps it a plain flop array.
    always_ff @(posedge src_clk_i) begin
        if (push) begin
            mem_q[wbin_q[LOG_DEPTH-1:0]] <= src_data_i;
        end
    end

    // ---------------- destination domain ----------------
    ptr_t                   rbin_q, rbin_d;
    ptr_t                   wbin_s;
    ptr_t [SYNC_STAGES-1:0] wgray_sync_q;
    logic                   pop;

    assign wbin_s      = gray2bin(wgray_sync_q[SYNC_STAGES-1]);
    assign dst_fill_o  = wbin_s - rbin_q;
    assign dst_valid_o = (dst_fill_o != '0);
    assign dst_data_o  = mem_q[rbin_q[LOG_DEPTH-1:0]];
    assign pop         = dst_valid_o && dst_ready_i;
    assign rbin_d      = pop ? rbin_q + ptr_t'(1) : rbin_q;

    always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
        if (!dst_rst_ni) begin
            rbin_q       <= '0;
            rgray_q      <= '0;
            wgray_sync_q <= '0;
        end else begin
            rbin_q       <= rbin_d;
            rgray_q      <= bin2gray(rbin_d);
            wgray_sync_q <= {wgray_sync_q[SYNC_STAGES-2:0], wgray_q};
        end
    end

endmodule

// File: tb/tb_cdc_fifo_gray_fill.sv
// Bench for cdc_fifo_gray_fill: a default instance for fill/drain, reset and
// streaming, and a SYNC_STAGES=3 / AF_THRESH=4 instance for latency and threshold.
`timescale 1ns/100ps
module tb_cdc_fifo_gray_fill;

    localparam int DW = 32;
    localparam int LD = 3;
    localparam int PW = LD + 1;

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          exp_ready;
        logic [PW-1:0] exp_fill;
        logic          exp_af;
    } vec_t;

    real  src_half = 5.0;
    real  dst_half = 13.5;
    logic src_clk = 1'b0;
    logic dst_clk = 1'b0;
    logic src_rst_n, dst_rst_n;

    // default instance
    logic [DW-1:0] src_data, dst_data;
    logic          src_valid, src_ready, src_af, dst_valid, dst_ready;
    logic [PW-1:0] src_fill, dst_fill;

    // SYNC_STAGES=3, AF_THRESH=4 instance
    logic [DW-1:0] b_src_data, b_dst_data;
    logic          b_src_valid, b_src_ready, b_src_af, b_dst_valid, b_dst_ready;
    logic [PW-1:0] b_src_fill, b_dst_fill;

    int            n_vec = 0;
    int            n_miss = 0;
    int            n_popped = 0;
    int            dst_mode = 0;
    logic          chk_order = 1'b0;
    logic [DW-1:0] sb [$];
    vec_t          vecs [9];

    cdc_fifo_gray_fill #(.DATA_WIDTH(DW), .LOG_DEPTH(LD), .SYNC_STAGES(2), .AF_THRESH(7)) u_dut (
        .src_clk_i(src_clk), .src_rst_ni(src_rst_n), .src_data_i(src_data),
        .src_valid_i(src_valid), .src_ready_o(src_ready), .src_fill_o(src_fill),
        .src_almost_full_o(src_af),
        .dst_clk_i(dst_clk), .dst_rst_ni(dst_rst_n), .dst_data_o(dst_data),
        .dst_valid_o(dst_valid), .dst_ready_i(dst_ready), .dst_fill_o(dst_fill)
    );

    cdc_fifo_gray_fill #(.DATA_WIDTH(DW), .LOG_DEPTH(LD), .SYNC_STAGES(3), .AF_THRESH(4)) u_dut_b (
        .src_clk_i(src_clk), .src_rst_ni(src_rst_n), .src_data_i(b_src_data),
        .src_valid_i(b_src_valid), .src_ready_o(b_src_ready), .src_fill_o(b_src_fill),
        .src_almost_full_o(b_src_af),
        .dst_clk_i(dst_clk), .dst_rst_ni(dst_rst_n), .dst_data_o(b_dst_data),
        .dst_valid_o(b_dst_valid), .dst_ready_i(b_dst_ready), .dst_fill_o(b_dst_fill)
    );

    initial forever #(src_half) src_clk = ~src_clk;
    initial forever #(dst_half) dst_clk = ~dst_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Destination driver and scoreboard checker: ready is chosen on the falling
    // edge, so the popped word is the one visible until the next rising edge.
    initial begin
        logic [DW-1:0] exp_d;
        dst_ready = 1'b0;
        forever begin
            @(negedge dst_clk);
            case (dst_mode)
                0:       dst_ready = 1'b0;
                1:       dst_ready = 1'b1;
                default: dst_ready = ($urandom_range(99) < 60);
            endcase
            if (dst_ready && dst_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no word", dst_data);
                end else begin
                    exp_d = sb.pop_front();
                    check("pop_data", dst_data, exp_d);
                end
                n_popped++;
            end
        end
    end

    initial forever begin
        @(negedge src_clk);
        if (chk_order) check("src_fill_ge_dst_fill", src_fill >= dst_fill, 1'b1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, idx, pop0;

        vecs[0] = '{1'b1, 32'h00, 1'b1, 4'd1, 1'b0};
        vecs[1] = '{1'b1, 32'h01, 1'b1, 4'd2, 1'b0};
        vecs[2] = '{1'b1, 32'h02, 1'b1, 4'd3, 1'b0};
        vecs[3] = '{1'b1, 32'h03, 1'b1, 4'd4, 1'b0};
        vecs[4] = '{1'b1, 32'h04, 1'b1, 4'd5, 1'b0};
        vecs[5] = '{1'b1, 32'h05, 1'b1, 4'd6, 1'b0};
        vecs[6] = '{1'b1, 32'h06, 1'b1, 4'd7, 1'b1};
        vecs[7] = '{1'b1, 32'h07, 1'b0, 4'd8, 1'b1};
        vecs[8] = '{1'b1, 32'h08, 1'b0, 4'd8, 1'b1};

        src_valid = 1'b0; src_data = '0;
        b_src_valid = 1'b0; b_src_data = '0; b_dst_ready = 1'b0;
        src_rst_n = 1'b0; dst_rst_n = 1'b0;

        // reset values
        #37;
        src_rst_n = 1'b1; dst_rst_n = 1'b1;
        repeat (10) @(posedge src_clk);
        @(negedge src_clk);
        check("rst_src_ready", src_ready, 1'b1);
        check("rst_src_fill", src_fill, 0);
        check("rst_src_af", src_af, 1'b0);
        check("rst_dst_valid", dst_valid, 1'b0);
        check("rst_dst_fill", dst_fill, 0);
        check("rst_b_src_af", b_src_af, 1'b0);
        check("rst_b_dst_valid", b_dst_valid, 1'b0);

        // fill from the table with the destination stalled, 9th push ignored
        for (int i = 0; i < 9; i++) begin
            @(negedge src_clk);
            src_valid = vecs[i].valid;
            src_data  = vecs[i].data;
            if (src_valid && src_ready) sb.push_back(src_data);
            @(posedge src_clk);
            #1;
            check($sformatf("fill_ready[%0d]", i), src_ready, vecs[i].exp_ready);
            check($sformatf("fill_level[%0d]", i), src_fill, vecs[i].exp_fill);
            check($sformatf("fill_af[%0d]", i), src_af, vecs[i].exp_af);
        end
        @(negedge src_clk);
        src_valid = 1'b0;
        check("fill_sb_depth", sb.size(), 8);

        // drain in order
        pop0 = n_popped;
        dst_mode = 1;
        cnt = 0;
        while ((sb.size() != 0 || dst_valid) && cnt < 200) begin
            @(negedge src_clk);
            cnt++;
        end
        dst_mode = 0;
        check("drain_in_time", cnt < 200, 1'b1);
        check("drain_count", n_popped - pop0, 8);
        check("drain_dst_valid", dst_valid, 1'b0);
        check("drain_dst_fill", dst_fill, 0);
        cnt = 0;
        while (src_fill != 0 && cnt < 10) begin
            @(posedge src_clk);
            #1;
            cnt++;
        end
        check($sformatf("src_fill_return_edges=%0d_le_3", cnt), cnt <= 3, 1'b1);
        check("drain_src_fill", src_fill, 0);
        check("drain_src_ready", src_ready, 1'b1);
        check("drain_src_af", src_af, 1'b0);

        // write-to-visible latency with three sync stages
        @(negedge src_clk);
        b_src_valid = 1'b1;
        b_src_data  = 32'hA5;
        @(posedge src_clk);
        fork
            begin #1 b_src_valid = 1'b0; end
        join_none
        cnt = 0;
        while (cnt < 8) begin
            @(posedge dst_clk);
            cnt++;
            #1;
            if (b_dst_valid) break;
        end
        check($sformatf("latency_edges=%0d_in_3_4", cnt), (cnt >= 3) && (cnt <= 4), 1'b1);
        check("latency_data", b_dst_data, 32'hA5);
        @(negedge dst_clk);
        b_dst_ready = 1'b1;
        @(negedge dst_clk);
        b_dst_ready = 1'b0;
        cnt = 0;
        while (b_src_fill != 0 && cnt < 20) begin
            @(negedge src_clk);
            cnt++;
        end
        check("latency_b_empty", b_src_fill, 0);

        // almost-full threshold of 4
        for (int i = 0; i < 4; i++) begin
            @(negedge src_clk);
            b_src_valid = 1'b1;
            b_src_data  = 32'h10 + i;
            @(posedge src_clk);
            #1;
            check($sformatf("af_fill[%0d]", i), b_src_fill, i + 1);
            check($sformatf("af_flag[%0d]", i), b_src_af, (i + 1) >= 4);
        end
        @(negedge src_clk);
        b_src_valid = 1'b0;
        @(negedge dst_clk);
        cnt = 0;
        while (!b_dst_valid && cnt < 20) begin
            @(negedge dst_clk);
            cnt++;
        end
        check("af_pop_valid", b_dst_valid, 1'b1);
        check("af_pop_data", b_dst_data, 32'h10);
        b_dst_ready = 1'b1;
        @(negedge dst_clk);
        b_dst_ready = 1'b0;
        @(negedge src_clk);
        check("af_still_set", b_src_af, b_src_fill >= 4);
        cnt = 0;
        while (b_src_fill == 4 && cnt < 20) begin
            @(posedge src_clk);
            #1;
            cnt++;
        end
        check("af_drop_fill", b_src_fill, 3);
        check("af_drop_flag", b_src_af, 1'b0);

        // reset with five words queued
        for (int i = 0; i < 5; i++) begin
            @(negedge src_clk);
            src_valid = 1'b1;
            src_data  = 32'h100 + i;
            if (src_ready) sb.push_back(src_data);
        end
        @(negedge src_clk);
        src_valid = 1'b0;
        repeat (20) @(negedge src_clk);
        check("pre_reset_dst_fill", dst_fill, 5);
        src_rst_n = 1'b0; dst_rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_src_ready", src_ready, 1'b1);
        check("midrst_src_fill", src_fill, 0);
        check("midrst_src_af", src_af, 1'b0);
        check("midrst_dst_valid", dst_valid, 1'b0);
        check("midrst_dst_fill", dst_fill, 0);
        check("midrst_b_src_fill", b_src_fill, 0);
        @(negedge src_clk);
        src_rst_n = 1'b1; dst_rst_n = 1'b1;
        repeat (3) @(negedge src_clk);
        src_valid = 1'b1;
        src_data  = 32'h42;
        if (src_ready) sb.push_back(src_data);
        @(negedge src_clk);
        src_valid = 1'b0;
        pop0 = n_popped;
        dst_mode = 1;
        cnt = 0;
        while ((sb.size() != 0 || dst_valid) && cnt < 100) begin
            @(negedge src_clk);
            cnt++;
        end
        dst_mode = 0;
        check("midrst_popped", n_popped - pop0, 1);

        // 100-word stream with random handshakes, ratio 3:7 then 7:3
        src_half = 3.0;
        dst_half = 7.0;
        repeat (4) @(negedge src_clk);
        pop0 = n_popped;
        idx = 0;
        cnt = 0;
        chk_order = 1'b1;
        dst_mode = 2;
        while (idx < 100 && cnt < 20000) begin
            @(negedge src_clk);
            cnt++;
            if (idx >= 50) begin
                src_half = 7.0;
                dst_half = 3.0;
            end
            src_valid = ($urandom_range(99) < 60);
            src_data  = DW'(idx);
            if (src_valid && src_ready) begin
                sb.push_back(src_data);
                idx++;
            end
        end
        @(negedge src_clk);
        src_valid = 1'b0;
        cnt = 0;
        while ((sb.size() != 0 || dst_valid) && cnt < 5000) begin
            @(negedge src_clk);
            cnt++;
        end
        dst_mode = 0;
        chk_order = 1'b0;
        check("stream_sent", idx, 100);
        check("stream_popped", n_popped - pop0, 100);
        check("stream_sb_empty", sb.size(), 0);
        repeat (10) @(negedge src_clk);
        check("stream_src_fill", src_fill, 0);
        check("stream_dst_valid", dst_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cdc_fifo_gray_fill.md
# cdc_fifo_gray_fill

Dual-clock FIFO that moves a DATA_WIDTH-bit stream from the src_clk_i domain to the dst_clk_i domain with valid/ready handshakes on both sides. Read and write pointers cross domains as Gray codes through a configurable-depth synchroniser chain. Each side gets a conservative fill level, and the source side gets an almost-full flag. Used wherever a clock-domain crossing needs flow-control headroom information, for example credit return or burst gating.

## Interface
- DATA_WIDTH, 32: payload width in bits.
- LOG_DEPTH, 3: FIFO depth is 2**LOG_DEPTH; must be ≥1.
- SYNC_STAGES, 2: number of flops in each pointer synchroniser; must be ≥2.
- AF_THRESH, 2**LOG_DEPTH-1: src_almost_full_o asserts when src_fill_o ≥ AF_THRESH; range 1..2**LOG_DEPTH.

Ports:
- src_clk_i, input, 1: source clock.
- src_rst_ni, input, 1: source reset; asynchronous, active-low; clock src_clk_i.
- src_data_i, input, DATA_WIDTH: push data.
- src_valid_i, input, 1: push request.
- src_ready_o, output, 1: FIFO not full as seen from the source side.
- src_fill_o, output, LOG_DEPTH+1: source-side occupancy, 0..2**LOG_DEPTH.
- src_almost_full_o, output, 1: src_fill_o ≥ AF_THRESH.
- dst_clk_i, input, 1: destination clock.
- dst_rst_ni, input, 1: destination reset; asynchronous, active-low.
- dst_data_o, output, DATA_WIDTH: head-of-FIFO data.
- dst_valid_o, output, 1: FIFO not empty as seen from the destination side.
- dst_ready_i, input, 1: pop acknowledge.
- dst_fill_o, output, LOG_DEPTH+1: destination-side occupancy.

## Operation
- **Pointers.** Binary write pointer wbin_q (src domain) and read pointer rbin_q (dst domain), each LOG_DEPTH+1 bits. Each has a registered Gray copy, gray = bin ^ (bin >> 1), updated on the same edge as the binary pointer. Only the Gray registers cross domains, each through SYNC_STAGES flops reset to 0 by the receiving domain's reset.
- **Pointer conversion.** Synchronised Gray values are converted back to binary in the receiving domain: wbin_s in dst, rbin_s in src.
- **Push.** A push occurs when src_valid_i && src_ready_o at a src_clk_i edge. On a push, mem[wbin_q[LOG_DEPTH-1:0]] ← src_data_i and wbin_q increments, wrapping modulo 2**(LOG_DEPTH+1).
- **Pop.** A pop occurs when dst_valid_o && dst_ready_i at a dst_clk_i edge; rbin_q increments.
- **Memory.** Flop array written in the src domain and not reset. dst_data_o = mem[rbin_q[LOG_DEPTH-1:0]] (fall-through, combinational read). dst_data_o is don't-care while dst_valid_o=0.
- **Fill levels.** src_fill_o = wbin_q − rbin_s and dst_fill_o = wbin_s − rbin_q, both modulo 2**(LOG_DEPTH+1).
  - src_fill_o over-estimates true occupancy and dst_fill_o under-estimates it. This is never unsafe.
- **Flags.**
  - src_ready_o = (src_fill_o != 2**LOG_DEPTH).
  - dst_valid_o = (dst_fill_o != 0).
  - src_almost_full_o = (src_fill_o ≥ AF_THRESH).
  - All flags are combinational from registered state; there is no combinational path from src_valid_i or dst_ready_i to any output.
- **Ignored requests.** src_valid_i while full is ignored, with no write and no pointer change. dst_ready_i while empty is ignored.
- **Wrap-around.** The extra MSB distinguishes full (pointers differ only in the MSB) from empty (pointers equal). The first wrap occurs after 2**(LOG_DEPTH+1) transfers.
- **Simultaneous push and pop** in the same wall-clock instant is legal. Each side sees the other's update only after synchronisation.
- **Reset.**
  - Both resets must be asserted together; reset of one domain alone is unsupported and has undefined contents.
  - Reset values: src_ready_o=1, src_fill_o=0, src_almost_full_o=0, dst_valid_o=0, dst_fill_o=0.
  - A push or pop in progress during reset is discarded.

## Timing
- **Write-to-visible latency.** After a push at src edge k, dst_valid_o rises SYNC_STAGES to SYNC_STAGES+1 dst_clk_i rising edges later. The extra edge allows for metastability resolution.
- **Pop-to-visible latency.** A pop frees a slot; src_ready_o and src_fill_o reflect it SYNC_STAGES to SYNC_STAGES+1 src_clk_i edges later.
- **Throughput.** Sustained throughput is one transfer per cycle of the slower clock, provided 2**LOG_DEPTH exceeds the round-trip latency, which is about 2·(SYNC_STAGES+1) cycles of the slower clock.
- **Single-bit change.** Each Gray pointer changes at most one bit per source edge.
- **Constraints.** A max-delay constraint of one destination period applies on Gray pointer paths into the first sync flop, and on mem → dst_data_o.

## Test plan
- **Reset values.** Assert both resets, release them, run 10 cycles idle → src_ready_o=1, dst_valid_o=0, both fills 0, src_almost_full_o=0.
- **Fill then drain.** LOG_DEPTH=3, src 100 MHz, dst 37 MHz, dst_ready_i=0; push 0x00..0x07 →
  - src_ready_o=0 after the 8th push, src_fill_o=8, src_almost_full_o set from fill 7;
  - a 9th push is ignored;
  - then raise dst_ready_i → pops 0x00..0x07 in order, dst_valid_o=0 afterwards, and src_fill_o returns to 0 within SYNC_STAGES+1 src cycles.
- **Latency.** SYNC_STAGES=3, single push 0xA5 → dst_valid_o rises on dst edge 3 or 4 after the push, with dst_data_o=0xA5.
- **Wrap-around.** Stream 100 words, values 0..99, with random valid/ready at clock ratio 3:7 and then 7:3 → in-order, loss-free delivery; pointers wrap ≥6 times; src_fill_o ≥ dst_fill_o at all times.
- **Reset mid-stream.** Both resets asserted with 5 words queued → all outputs return to reset values; the next pushed word 0x42 is the first popped.
- **Almost-full threshold.** AF_THRESH=4 → src_almost_full_o asserts on the cycle src_fill_o reaches 4 and deasserts when src_fill_o drops to 3.
